demux_tdm_scheduler: RTL and testbench
======================================

# demux_tdm_scheduler

Time-division scheduler that drives the select of a 1:8 demultiplexer, steering a single serial input `din` to each enabled output channel in turn. Each enabled channel is held for a programmable dwell period, and channels are visited in ascending index order with wrap-around. The block also contains the demux stage and presents one-hot gated outputs. It sits between a single data source and eight channel consumers, and replaces hand-driven select lines.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell count. Each channel is held for `dwell+1` cycles.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: run enable.
- `mask`, input, 8: channel enable mask (bit i enables channel i). Sampled only at frame boundaries.
- `dwell`, input, `DWELL_W`: dwell length minus one. Sampled with `mask`.
- `din`, input, 1: serial data to distribute.
- `y`, output, 8: demux outputs, `y[sel] = din` while `busy`; all other bits are 0.
- `sel`, output, 3: registered current channel select.
- `busy`, output, 1: high in RUN.
- `frame_start`, output, 1: one-cycle pulse in the first cycle of each frame.

## Operation
- States: IDLE and RUN. Internal registers: `state`, `sel`, `cnt` (`DWELL_W` bits), `act_mask` (8 bits), `act_dwell` (`DWELL_W` bits).
- Reset values: state=IDLE, `sel`=0, `cnt`=0, `act_mask`=0, `act_dwell`=0, `busy`=0, `frame_start`=0, `y`=0.
- `y` is combinational: `y = busy ? (din << sel) : 0`. There is no latency from `din` to `y`.
- IDLE to RUN, when `en`=1 and `mask`≠0:
  - `act_mask`<=`mask`, `act_dwell`<=`dwell`.
  - `sel`<=lowest set bit of `mask`, `cnt`<=0.
  - `frame_start`<=1.
- IDLE with `en`=0 or `mask`=0: stay in IDLE. All outputs hold their reset values.
- RUN with `en`=0: go to IDLE the next cycle. `sel`<=0, `cnt`<=0, `busy`<=0. An in-progress dwell is abandoned.
- RUN with `en`=1 and `cnt`<`act_dwell`: `cnt`<=`cnt`+1, `sel` holds.
- RUN with `en`=1 and `cnt`==`act_dwell`: `cnt`<=0, then:
  - If there is a set bit in `act_mask` above `sel`: `sel`<=the lowest such bit.
  - Otherwise this is the frame end. Reload `act_mask`<=`mask` and `act_dwell`<=`dwell`.
    - If the new `mask`=0, go to IDLE (`busy`<=0, `sel`<=0).
    - Otherwise `sel`<=lowest set bit of the new `mask` and `frame_start`<=1.
- `frame_start` is 0 in every other cycle.
- Mask and dwell changes mid-frame are ignored until the frame end. This guarantees no channel is skipped or duplicated within a frame.
- Single enabled channel: every dwell end is a frame end. `frame_start` pulses every `dwell+1` cycles, and `sel` stays constant.
- `dwell`=0: `sel` advances every cycle.
- Counter arithmetic is unsigned `DWELL_W`-bit. `cnt` never exceeds `act_dwell`, so the counter never wraps.

## Timing
- From the `en` rise (with a nonzero `mask`) sampled at edge N: `busy`, `sel`, and `frame_start` are valid after edge N.
- Frame length is `popcount(act_mask)·(act_dwell+1)` cycles.
- A `sel` change is registered: a change takes effect on the edge after `cnt`==`act_dwell` is observed.
- `en` drop sampled at edge N: `busy`=0 and `y`=0 after edge N.
- Asynchronous `rst` mid-frame: all registers are immediately forced to their reset values, and `y` goes to 0 combinationally. After release, the block restarts from IDLE.

## Structure
- Shared package `demux_pkg`, containing:
  - `NCH`=8 and `SEL_W`=3.
  - State enum `sched_state_t` {IDLE, RUN}.
- Sub-module `next_set_bit`: a combinational rotate-priority finder.
  - Inputs: 8-bit mask and 3-bit current index.
  - Outputs: next set index strictly above current, a `found` flag, and the lowest set index.
  - This is used for both advance and frame start.

## Test plan
- Reset, then `en`=1, `mask`=8'hFF, `dwell`=0: `sel` steps 0,1,…,7,0. `frame_start` pulses on `sel`=0. With `din`=1, `y` walks 01,02,…,80.
- `mask`=8'b1010_0100, `dwell`=2: `sel` sequence is 2,2,2,5,5,5,7,7,7,2… `frame_start` pulses every 9 cycles.
- Mid-frame `mask` change from 8'hFF to 8'h01 while `sel`=3: channels 4–7 are still visited. After the frame end, `sel` stays at 0 and `frame_start` pulses every `dwell+1` cycles.
- Frame-end `mask`=0: `busy` falls after the last channel's dwell, and `y`=0. A later `mask`=8'h10 restarts with `sel`=4 and `frame_start`=1.
- Drop `en` when `cnt`=1 of `dwell`=5: next cycle `busy`=0, `sel`=0, `y`=0. Re-enabling restarts the frame at the lowest enabled channel.
- Assert `rst` asynchronously mid-dwell: `y`, `sel`, `busy`, and `frame_start` go to 0 before the next clock edge. No output activity until `en` is reasserted.

Source files
------------

// File: rtl/demux_tdm_scheduler_pkg.sv
// Shared constants and state encoding for the TDM demux scheduler.
package demux_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/demux_tdm_scheduler_next_set_bit.sv
// Combinational finder: next set channel strictly above cur, and the lowest set channel.
module next_set_bit
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next_idx,
  output logic             found,
  output logic [SEL_W-1:0] low_idx
);

  always_comb begin
    logic low_hit;
    next_idx = '0;
    found    = 1'b0;
    low_idx  = '0;
    low_hit  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mask[i] && !low_hit) begin
        low_idx = SEL_W'(i);
        low_hit = 1'b1;
      end
      // found clear means the scan wrapped: the caller treats that as frame end
      if (mask[i] && !found && (i > 32'(cur))) begin
        next_idx = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_tdm_scheduler.sv
// Time-division scheduler steering din onto eight one-hot gated outputs,
// holding each enabled channel for dwell+1 cycles in ascending order.
module demux_tdm_scheduler
  import demux_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic [NCH-1:0]     y,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               frame_start
);

  sched_state_t       state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]     act_mask_q, act_mask_d;
  logic [DWELL_W-1:0] act_dwell_q, act_dwell_d;
  logic               busy_q, busy_d;
  logic               frame_start_q, frame_start_d;

  logic [SEL_W-1:0]   adv_next, adv_low, new_next, new_low;
  logic               adv_found, new_found;
  logic               unused_finder;

  // Advance search runs over the latched frame mask; restart search over the live mask.
  next_set_bit u_adv (
    .mask     (act_mask_q),
    .cur      (sel_q),
    .next_idx (adv_next),
    .found    (adv_found),
    .low_idx  (adv_low)
  );

  next_set_bit u_new (
    .mask     (mask),
    .cur      (sel_q),
    .next_idx (new_next),
    .found    (new_found),
    .low_idx  (new_low)
  );

  assign unused_finder = ^{adv_low, new_next, new_found};

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    act_mask_d    = act_mask_q;
    act_dwell_d   = act_dwell_q;
    busy_d        = busy_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (mask != '0)) begin
          state_d       = RUN;
          busy_d        = 1'b1;
          act_mask_d    = mask;
          act_dwell_d   = dwell;
          sel_d         = new_low;
          cnt_d         = '0;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q < act_dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (adv_found) begin
            sel_d = adv_next;
          end else begin
            act_mask_d  = mask;
            act_dwell_d = dwell;
            if (mask == '0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              sel_d   = '0;
            end else begin
              sel_d         = new_low;
              frame_start_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      act_mask_q    <= '0;
      act_dwell_q   <= '0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      act_mask_q    <= act_mask_d;
      act_dwell_q   <= act_dwell_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign y           = busy_q ? (NCH'(din) << sel_q) : '0;

endmodule

// File: tb/tb_demux_tdm_scheduler.sv
// Directed bench for demux_tdm_scheduler: vector table plus multi-cycle corner sequences.
module tb_demux_tdm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic       din;
  logic [7:0] y;
  logic [2:0] sel;
  logic       busy;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       din;
    logic [2:0] sel;
    logic       busy;
    logic       fs;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[$];

  demux_tdm_scheduler #(.DWELL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mask        (mask),
    .dwell       (dwell),
    .din         (din),
    .y           (y),
    .sel         (sel),
    .busy        (busy),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] e_sel, input logic e_busy,
                     input logic e_fs, input logic [7:0] e_y);
    checks++;
    if (sel !== e_sel || busy !== e_busy || frame_start !== e_fs || y !== e_y) begin
      failures++;
      $display("FAIL %s: got sel=%0d busy=%b fs=%b y=%02h, want sel=%0d busy=%b fs=%b y=%02h",
               name, sel, busy, frame_start, y, e_sel, e_busy, e_fs, e_y);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] one;
    logic [2:0] s2 [10];
    logic       d2 [10];
    logic [7:0] y2 [10];
    one = 8'h01;
    s2 = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd2};
    d2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    y2 = '{8'h04, 8'h00, 8'h04, 8'h20, 8'h00, 8'h20, 8'h80, 8'h80, 8'h00, 8'h04};

    // all channels, dwell 0: one channel per cycle, frame restarts on channel 0
    for (int k = 0; k < 8; k++)
      vecs.push_back('{1'b1, 8'hFF, 8'd0, 1'b1, 3'(k), 1'b1, (k == 0), one << k});
    vecs.push_back('{1'b1, 8'hFF, 8'd0, 1'b1, 3'd0, 1'b1, 1'b1, 8'h01});
    vecs.push_back('{1'b0, 8'hFF, 8'd0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00});
    // sparse mask A4, dwell 2: 2,2,2,5,5,5,7,7,7,2 with din toggled to exercise gating
    for (int k = 0; k < 10; k++)
      vecs.push_back('{1'b1, 8'hA4, 8'd2, d2[k], s2[k], 1'b1, (k == 0 || k == 9), y2[k]});
    vecs.push_back('{1'b0, 8'hA4, 8'd2, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00});

    rst = 1'b1; en = 1'b0; mask = '0; dwell = '0; din = 1'b1;
    #12;
    chk("reset", 3'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step();
    chk("idle_after_reset", 3'd0, 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      en = vecs[i].en; mask = vecs[i].mask; dwell = vecs[i].dwell; din = vecs[i].din;
      step();
      chk($sformatf("vec%0d", i), vecs[i].sel, vecs[i].busy, vecs[i].fs, vecs[i].y);
    end

    // mid-frame mask change is deferred to the frame end
    en = 1'b1; mask = 8'hFF; dwell = 8'd1; din = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("midmask_e%0d", e), 3'((e - 1) / 2), 1'b1, (e == 1), one << ((e - 1) / 2));
    end
    mask = 8'h01;
    for (int e = 8; e <= 16; e++) begin
      step();
      chk($sformatf("midmask_e%0d", e), 3'((e - 1) / 2), 1'b1, 1'b0, one << ((e - 1) / 2));
    end
    step(); chk("single_ch_fs1", 3'd0, 1'b1, 1'b1, 8'h01);
    step(); chk("single_ch_hold", 3'd0, 1'b1, 1'b0, 8'h01);
    step(); chk("single_ch_fs2", 3'd0, 1'b1, 1'b1, 8'h01);
    en = 1'b0;
    step(); chk("midmask_stop", 3'd0, 1'b0, 1'b0, 8'h00);

    // zero mask at frame end drops busy; later mask 10 restarts on channel 4
    en = 1'b1; mask = 8'h03; dwell = 8'd0;
    step(); chk("zm_start", 3'd0, 1'b1, 1'b1, 8'h01);
    mask = 8'h00;
    step(); chk("zm_last_ch", 3'd1, 1'b1, 1'b0, 8'h02);
    step(); chk("zm_idle", 3'd0, 1'b0, 1'b0, 8'h00);
    step(); chk("zm_stay_idle", 3'd0, 1'b0, 1'b0, 8'h00);
    mask = 8'h10;
    step(); chk("zm_restart", 3'd4, 1'b1, 1'b1, 8'h10);
    en = 1'b0;
    step(); chk("zm_stop", 3'd0, 1'b0, 1'b0, 8'h00);

    // en drop at cnt=1 of dwell 5 abandons the dwell
    en = 1'b1; mask = 8'h06; dwell = 8'd5;
    step(); chk("drop_start", 3'd1, 1'b1, 1'b1, 8'h02);
    step(); chk("drop_cnt1", 3'd1, 1'b1, 1'b0, 8'h02);
    en = 1'b0;
    step(); chk("drop_idle", 3'd0, 1'b0, 1'b0, 8'h00);
    en = 1'b1;
    step(); chk("drop_reenable", 3'd1, 1'b1, 1'b1, 8'h02);
    step(); chk("drop_reenable_hold", 3'd1, 1'b1, 1'b0, 8'h02);

    // asynchronous reset mid-dwell clears outputs before the next edge
    #2 rst = 1'b1;
    #1 chk("async_rst", 3'd0, 1'b0, 1'b0, 8'h00);
    en = 1'b0;
    #2 rst = 1'b0;
    step(); chk("post_rst_idle1", 3'd0, 1'b0, 1'b0, 8'h00);
    step(); chk("post_rst_idle2", 3'd0, 1'b0, 1'b0, 8'h00);
    en = 1'b1;
    step(); chk("post_rst_restart", 3'd1, 1'b1, 1'b1, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
